// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between the core MEM stage and a debug burst port.
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 4,
  parameter int MAX_WAIT   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_rd,
  input  logic                  core_wr,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [2:0]            core_funct3,
  output logic                  core_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [DM_ADDRESS-1:0] dbg_addr,
  input  logic [LEN_W-1:0]      dbg_len,
  output logic                  dbg_ready,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_beat,
  output logic                  dbg_rvalid,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  dbg_done,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata
);
  localparam int WW = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WW-1:0] MAXW = WW'(MAX_WAIT);
  typedef enum logic {IDLE, BURST} state_t;
  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic                  rvalid_q, rvalid_d;
  logic                  done_q, done_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  core_acc, core_win, beat;
  always_comb begin
    core_acc   = core_rd | core_wr;
    core_win   = core_acc && (wait_q < MAXW);
    beat       = (state_q == BURST) && !core_win;
    mem_rd     = beat ? ~we_q : core_rd;
    mem_wr     = beat ? we_q : core_wr;
    mem_addr   = beat ? addr_q : core_addr;
    mem_wdata  = beat ? dbg_wdata : core_wdata;
    mem_funct3 = beat ? 3'b010 : core_funct3;
    core_stall = beat & core_acc;
    dbg_beat   = beat;
    dbg_ready  = state_q == IDLE;
    state_d    = state_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wait_d     = wait_q;
    rvalid_d   = beat & ~we_q;
    rdata_d    = rvalid_d ? mem_rdata : rdata_q;
    done_d     = beat && cnt_q == '0;
    if (state_q == IDLE && dbg_req) begin
      state_d = BURST;
      we_d    = dbg_we;
      cnt_d   = dbg_len;
      addr_d  = {dbg_addr[DM_ADDRESS-1:2], 2'b00};
      wait_d  = '0;
    end else if (beat) begin
      addr_d  = addr_q + DM_ADDRESS'(4);
      cnt_d   = cnt_q - LEN_W'(1);
      wait_d  = '0;
      state_d = cnt_q == '0 ? IDLE : BURST;
    end else if (state_q == BURST) begin
      wait_d  = wait_q + WW'(1);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wait_q   <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wait_q   <= wait_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
    end
  end
  assign dbg_rvalid = rvalid_q;
  assign dbg_done   = done_q;
  assign dbg_rdata  = rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: runs MAX_WAIT=3 and MAX_WAIT=0 arbiters side by side against a burst-level model.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        core_rd = 1'b0, core_wr = 1'b0;
  logic [8:0]  core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic [2:0]  core_funct3 = '0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [8:0]  dbg_addr = '0;
  logic [3:0]  dbg_len = '0;
  logic [31:0] dbg_wdata = '0;
  logic        o_core_stall [2], o_dbg_ready [2], o_dbg_beat [2], o_dbg_rvalid [2], o_dbg_done [2];
  logic        o_mem_rd [2], o_mem_wr [2];
  logic [8:0]  o_mem_addr [2];
  logic [31:0] o_mem_wdata [2], o_dbg_rdata [2], mem_rdata_w [2];
  logic [2:0]  o_mem_funct3 [2];
  int          npass = 0, ntotal = 0;
  int          maxw [2] = '{3, 0};
  logic        m_busy [2], m_we [2], e_rv [2], e_done [2];
  int          m_left [2], m_addr [2], m_wt [2];
  logic [31:0] e_rd [2];
  logic [31:0] refmem [2][128];
  logic [8:0]  beats0 [$];
  always #5 clk = ~clk;
  function automatic logic [31:0] init_word(int k);
    return (32'(k) * 32'h01000193) ^ 32'hC0DE0000;
  endfunction
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] emem [128];
    initial for (int k = 0; k < 128; k++) emem[k] = init_word(k);
    always @(posedge clk) if (o_mem_wr[g]) emem[o_mem_addr[g][8:2]] <= o_mem_wdata[g];
    assign mem_rdata_w[g] = emem[o_mem_addr[g][8:2]];
    dmem_arbiter #(.MAX_WAIT(g == 0 ? 3 : 0)) u_dut (
      .clk(clk), .reset(reset),
      .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_funct3(core_funct3), .core_stall(o_core_stall[g]),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_len(dbg_len),
      .dbg_ready(o_dbg_ready[g]), .dbg_wdata(dbg_wdata), .dbg_beat(o_dbg_beat[g]),
      .dbg_rvalid(o_dbg_rvalid[g]), .dbg_rdata(o_dbg_rdata[g]), .dbg_done(o_dbg_done[g]),
      .mem_rd(o_mem_rd[g]), .mem_wr(o_mem_wr[g]), .mem_addr(o_mem_addr[g]),
      .mem_wdata(o_mem_wdata[g]), .mem_funct3(o_mem_funct3[g]), .mem_rdata(mem_rdata_w[g])
    );
  end
  task automatic chk(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
    ntotal++;
    assert (got === exp) npass++;
    else $error("FAIL %s[%0d] got %0h expected %0h", tag, i, got, exp);
  endtask
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0; m_wt[i] = 0; e_rv[i] = 1'b0; e_done[i] = 1'b0; e_rd[i] = '0;
    end
  endtask
  // One clock: check every output of both arbiters mid-cycle, then advance the model.
  task automatic cycle();
    logic ca, cw, bt;
    @(negedge clk);
    ca = core_rd | core_wr;
    for (int i = 0; i < 2; i++) begin
      cw = m_busy[i] && ca && (m_wt[i] < maxw[i]);
      bt = m_busy[i] && !cw;
      chk("mem_rd", i, o_mem_rd[i], bt ? !m_we[i] : core_rd);
      chk("mem_wr", i, o_mem_wr[i], bt ? m_we[i] : core_wr);
      chk("mem_addr", i, o_mem_addr[i], bt ? m_addr[i] : core_addr);
      chk("mem_wdata", i, o_mem_wdata[i], bt ? dbg_wdata : core_wdata);
      chk("mem_funct3", i, o_mem_funct3[i], bt ? 3'b010 : core_funct3);
      chk("core_stall", i, o_core_stall[i], bt && ca);
      chk("dbg_beat", i, o_dbg_beat[i], bt);
      chk("dbg_ready", i, o_dbg_ready[i], !m_busy[i]);
      chk("dbg_rvalid", i, o_dbg_rvalid[i], e_rv[i]);
      chk("dbg_rdata", i, o_dbg_rdata[i], e_rd[i]);
      chk("dbg_done", i, o_dbg_done[i], e_done[i]);
      if (i == 0 && o_dbg_beat[0]) beats0.push_back(o_mem_addr[0]);
      e_rv[i] = bt && !m_we[i];
      if (e_rv[i]) e_rd[i] = refmem[i][m_addr[i] / 4];
      e_done[i] = bt && m_left[i] == 1;
      if (bt) begin
        if (m_we[i]) refmem[i][m_addr[i] / 4] = dbg_wdata;
        m_addr[i] = (m_addr[i] + 4) % 512;
        m_left[i]--;
        m_wt[i] = 0;
        if (m_left[i] == 0) m_busy[i] = 1'b0;
      end else begin
        if (core_wr) refmem[i][core_addr / 4] = core_wdata;
        if (cw) m_wt[i]++;
        else if (!m_busy[i] && dbg_req) begin
          m_busy[i] = 1'b1; m_we[i] = dbg_we; m_addr[i] = dbg_addr & 9'h1FC;
          m_left[i] = dbg_len + 1; m_wt[i] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic burst(input logic we, input logic [8:0] a, input logic [3:0] len, input int n);
    beats0.delete();
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_len = len;
    cycle();
    dbg_req = 1'b0;
    repeat (n) begin
      dbg_wdata = $urandom;
      cycle();
    end
  endtask
  initial begin
    int bad;
    for (int i = 0; i < 2; i++) for (int k = 0; k < 128; k++) refmem[i][k] = init_word(k);
    model_reset();
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", i, o_dbg_ready[i], 1);
      chk("rst_rvalid", i, o_dbg_rvalid[i], 0);
      chk("rst_done", i, o_dbg_done[i], 0);
      chk("rst_rdata", i, o_dbg_rdata[i], 0);
    end
    @(posedge clk); #1 reset = 1'b1;
    core_rd = 1'b1; core_addr = 9'h040;
    #1;
    chk("idle_mem_rd", 0, o_mem_rd[0], 1);
    chk("idle_mem_addr", 0, o_mem_addr[0], 9'h040);
    chk("idle_stall", 0, o_core_stall[0], 0);
    cycle();
    core_rd = 1'b0;
    burst(1'b0, 9'h103, 4'd3, 6);
    chk("rd_beats", 0, beats0.size(), 4);
    for (int k = 0; k < 4 && k < beats0.size(); k++) chk("rd_beat_addr", k, beats0[k], 9'h100 + 9'(4 * k));
    core_wr = 1'b1; core_addr = 9'h080; core_wdata = 32'h5A5A0001; core_funct3 = 3'b010;
    burst(1'b1, 9'h010, 4'd1, 10);
    chk("starve_beats", 0, beats0.size(), 2);
    core_wdata = 32'h5A5A0002;
    burst(1'b1, 9'h030, 4'd2, 14);
    core_wr = 1'b0;
    cycle();
    burst(1'b0, 9'h1FC, 4'd1, 4);
    chk("wrap_beats", 0, beats0.size(), 2);
    if (beats0.size() == 2) begin
      chk("wrap_a0", 0, beats0[0], 9'h1FC);
      chk("wrap_a1", 0, beats0[1], 9'h000);
    end
    burst(1'b0, 9'h020, 4'd7, 2);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("mid_rst_ready", i, o_dbg_ready[i], 1);
      chk("mid_rst_beat", i, o_dbg_beat[i], 0);
      chk("mid_rst_done", i, o_dbg_done[i], 0);
    end
    model_reset();
    @(posedge clk); #1 reset = 1'b1;
    beats0.delete();
    repeat (3) cycle();
    chk("post_rst_beats", 0, beats0.size(), 0);
    burst(1'b0, 9'h0A0, 4'd0, 3);
    chk("new_burst_n", 0, beats0.size(), 1);
    if (beats0.size() == 1) chk("new_burst_a", 0, beats0[0], 9'h0A0);
    repeat (400) begin
      core_rd = 1'b0; core_wr = 1'b0;
      case ($urandom_range(3))
        0: core_rd = 1'b1;
        1: core_wr = 1'b1;
        default: ;
      endcase
      core_addr = 9'($urandom); core_wdata = $urandom; core_funct3 = 3'($urandom);
      dbg_req = $urandom_range(3) == 0; dbg_we = 1'($urandom);
      dbg_addr = 9'($urandom); dbg_len = 4'($urandom_range(5)); dbg_wdata = $urandom;
      cycle();
    end
    core_rd = 1'b0; core_wr = 1'b0; dbg_req = 1'b0;
    repeat (20) cycle();
    bad = 0;
    for (int k = 0; k < 128; k++) if (g_dut[0].emem[k] !== refmem[0][k]) bad++;
    chk("mem_image", 0, bad, 0);
    bad = 0;
    for (int k = 0; k < 128; k++) if (g_dut[1].emem[k] !== refmem[1][k]) bad++;
    chk("mem_image", 1, bad, 0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
